// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM/WB stages and a
// line-wide memory port; raises miss while a line is swapped so the pipeline stalls.
module dcache_wb #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 6,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     addr,
    input  logic                            rd_req,
    input  logic                            wr_req,
    input  logic [3:0]                      wr_be,
    input  logic [31:0]                     wr_data,
    output logic [31:0]                     rd_data,
    output logic                            miss,
    output logic [31:0]                     mem_addr,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
    input  logic                            mem_gnt
);
    localparam int SETS      = 1 << SET_ADDR_LEN;
    localparam int LINE_BITS = 32 << LINE_ADDR_LEN;
    localparam int OFS_BITS  = LINE_ADDR_LEN + 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [SETS-1:0]           valid_q, dirty_q;
    logic [TAG_ADDR_LEN-1:0]   tag_q [SETS];
    logic [LINE_BITS-1:0]      data_q [SETS];
    logic [LINE_BITS-1:0]      line_q;
    logic [TAG_ADDR_LEN-1:0]   req_tag_q, req_tag_d;
    logic [SET_ADDR_LEN-1:0]   req_set_q, req_set_d;
    logic [31:0]               rd_data_q;
    logic [31:0]               mem_addr_q, mem_addr_d;
    logic                      mem_rd_req_q, mem_rd_req_d;
    logic                      mem_wr_req_q, mem_wr_req_d;

    logic [LINE_ADDR_LEN-1:0]  word_s;
    logic [SET_ADDR_LEN-1:0]   set_s;
    logic [TAG_ADDR_LEN-1:0]   tag_s;
    logic                      hit_s, req_s, rd_hit_s, wr_hit_s;
    logic [LINE_BITS-1:0]      hit_line_s, merged_line_s;
    logic [31:0]               hit_word_s;
    logic                      unused_s;

    // Byte-merge a store into one word of a line.
    function automatic logic [LINE_BITS-1:0] merge_line(
        input logic [LINE_BITS-1:0]     line,
        input logic [LINE_ADDR_LEN-1:0] word,
        input logic [3:0]               be,
        input logic [31:0]              data
    );
        logic [LINE_BITS-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[{word, 5'b00000} + 8*b +: 8] = data[8*b +: 8];
            end
        end
        return r;
    endfunction

    assign word_s        = addr[OFS_BITS-1:2];
    assign set_s         = addr[OFS_BITS +: SET_ADDR_LEN];
    assign tag_s         = addr[31 -: TAG_ADDR_LEN];
    assign unused_s      = ^addr[1:0];
    assign req_s         = rd_req || wr_req;
    assign hit_s         = valid_q[set_s] && (tag_q[set_s] == tag_s);
    assign rd_hit_s      = (state_q == IDLE) && rd_req && !wr_req && hit_s;
    assign wr_hit_s      = (state_q == IDLE) && wr_req && hit_s;
    assign hit_line_s    = data_q[set_s];
    assign hit_word_s    = hit_line_s[{word_s, 5'b00000} +: 32];
    assign merged_line_s = merge_line(hit_line_s, word_s, wr_be, wr_data);

    // The stall must be seen by the requesting instruction in the same cycle.
    assign miss        = (state_q != IDLE) || (req_s && !hit_s);
    assign rd_data     = rd_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    // Set is latched at miss time so the victim stays put even if the core drops the request.
    assign mem_wr_line = data_q[req_set_q];

    // Next-state and next memory-request decode; request outputs follow the state being entered.
    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_set_d    = req_set_q;
        mem_rd_req_d = 1'b0;
        mem_wr_req_d = 1'b0;
        mem_addr_d   = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_s && !hit_s) begin
                    req_tag_d = tag_s;
                    req_set_d = set_s;
                    if (valid_q[set_s] && dirty_q[set_s]) begin
                        state_d      = SWAP_OUT;
                        mem_wr_req_d = 1'b1;
                        mem_addr_d   = {tag_q[set_s], set_s, {OFS_BITS{1'b0}}};
                    end else begin
                        state_d      = SWAP_IN;
                        mem_rd_req_d = 1'b1;
                        mem_addr_d   = {tag_s, set_s, {OFS_BITS{1'b0}}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SWAP_OUT: begin
                if (mem_gnt) begin
                    state_d      = SWAP_IN;
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = {req_tag_q, req_set_q, {OFS_BITS{1'b0}}};
                end else begin
                    mem_wr_req_d = 1'b1;
                    mem_addr_d   = {tag_q[req_set_q], req_set_q, {OFS_BITS{1'b0}}};
                end
            end
            SWAP_IN: begin
                if (mem_gnt) begin
                    state_d = SWAP_IN_OK;
                end else begin
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = {req_tag_q, req_set_q, {OFS_BITS{1'b0}}};
                end
            end
            SWAP_IN_OK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, valid/dirty bits and registered outputs; reset abandons any swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            req_tag_q    <= '0;
            req_set_q    <= '0;
            rd_data_q    <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_set_q    <= req_set_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            if (state_q == SWAP_IN_OK) begin
                valid_q[req_set_q] <= 1'b1;
                dirty_q[req_set_q] <= 1'b0;
            end else if (wr_hit_s) begin
                dirty_q[set_s] <= 1'b1;
            end
            if (rd_hit_s) begin
                rd_data_q <= hit_word_s;
            end
        end
    end

    // Tag/data arrays and the fill buffer carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if ((state_q == SWAP_IN) && mem_gnt) begin
            line_q <= mem_rd_line;
        end
        if (state_q == SWAP_IN_OK) begin
            data_q[req_set_q] <= line_q;
            tag_q[req_set_q]  <= req_tag_q;
        end else if (wr_hit_s) begin
            data_q[set_s] <= merged_line_s;
        end
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Randomised scoreboard bench for dcache_wb: a set-level cache model plus backing memory
// predicts load data and every line transfer; monitors pop and compare independently.
module tb_dcache_wb;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr, wr_data, rd_data, mem_addr;
    logic         rd_req, wr_req, miss, mem_rd_req, mem_wr_req, mem_gnt;
    logic [3:0]   wr_be;
    logic [255:0] mem_wr_line, mem_rd_line;

    dcache_wb dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(rd_data), .miss(miss),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [31:0]  a;
        logic [255:0] line;
    } memtx_t;

    memtx_t       exp_mem[$];
    logic [31:0]  exp_rd[$];
    int           checks = 0;
    int           failures = 0;
    bit           mem_hold = 1'b0;
    bit           late_gnt = 1'b0;
    bit           late_done = 1'b0;

    bit           m_valid[64];
    bit           m_dirty[64];
    logic [20:0]  m_tag[64];
    logic [255:0] m_line[64];
    logic [255:0] mem[logic [31:0]];

    task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ((la + 32'(w*4)) * 32'h0100_0193) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Issue one request: update the model, queue expectations, then hold it until accepted.
    task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [3:0] be, input logic [31:0] d);
        int          s, w, n;
        logic [20:0] tg;
        logic [31:0] la, va;
        bit          hitm;
        memtx_t      t;
        s = int'(a[10:5]); w = int'(a[4:2]); tg = a[31:11]; la = {a[31:5], 5'b0};
        hitm = m_valid[s] && (m_tag[s] == tg);
        if (rd || wr) begin
            if (!hitm) begin
                if (m_valid[s] && m_dirty[s]) begin
                    va = {m_tag[s], 6'(s), 5'b0};
                    t.wr = 1'b1; t.a = va; t.line = m_line[s];
                    exp_mem.push_back(t);
                    mem[va] = m_line[s];
                end
                t.wr = 1'b0; t.a = la; t.line = '0;
                exp_mem.push_back(t);
                m_line[s] = get_line(la); m_valid[s] = 1'b1; m_tag[s] = tg; m_dirty[s] = 1'b0;
            end
            if (wr) begin
                m_line[s][w*32 +: 32] = merge(m_line[s][w*32 +: 32], d, be);
                m_dirty[s] = 1'b1;
            end else begin
                exp_rd.push_back(m_line[s][w*32 +: 32]);
            end
        end
        addr = a; rd_req = rd; wr_req = wr; wr_be = be; wr_data = d;
        @(negedge clk);
        if (rd || wr) chk(miss == !hitm, "miss_first", miss, !hitm);
        n = 0;
        while (miss && n < 60) begin @(negedge clk); n++; end
        if (miss) chk(1'b0, "miss_timeout", miss, 0);
        else if (rd || wr) chk(exp_mem.size() == 0, "swap_done", exp_mem.size(), 0);
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    // Load-data monitor: a read accepted this cycle is checked next cycle; otherwise rd_data must hold.
    logic [31:0] last_rd = 32'd0;
    bit          pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            last_rd = 32'd0; pend = 1'b0;
        end else begin
            if (pend) begin
                if (exp_rd.size() == 0) chk(1'b0, "rd_unexpected", rd_data, 0);
                else begin
                    last_rd = exp_rd.pop_front();
                    chk(rd_data == last_rd, "rd_data", rd_data, last_rd);
                end
            end else begin
                chk(rd_data == last_rd, "rd_hold", rd_data, last_rd);
            end
            pend = rd_req && !wr_req && !miss;
        end
    end

    // Memory responder: checks each line request against the queue, grants after random latency.
    initial begin
        memtx_t e;
        int     lat;
        mem_gnt = 1'b0; mem_rd_line = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            if (rst) continue;
            if (mem_hold) begin
                if (late_gnt && !late_done) begin mem_gnt = 1'b1; late_done = 1'b1; end
                continue;
            end
            if (mem_rd_req || mem_wr_req) begin
                chk(!(mem_rd_req && mem_wr_req), "mem_excl", {mem_rd_req, mem_wr_req}, 0);
                if (exp_mem.size() == 0) chk(1'b0, "mem_unexpected", mem_addr, 0);
                else begin
                    e = exp_mem.pop_front();
                    chk(mem_wr_req == e.wr, "mem_dir", mem_wr_req, e.wr);
                    chk(mem_addr == e.a, "mem_addr", mem_addr, e.a);
                    if (e.wr) chk(mem_wr_line == e.line, "wb_line", mem_wr_line, e.line);
                end
                lat = int'($urandom_range(0, 3));
                repeat (lat) @(negedge clk);
                if (mem_rd_req) mem_rd_line = get_line(mem_addr);
                mem_gnt = 1'b1;
            end
        end
    end

    initial begin
        logic [255:0] l;
        int           n, k;
        logic [31:0]  a;
        rst = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_be = '0; wr_data = '0;
        for (int i = 0; i < 64; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
        l = get_line(32'h0000_0100);
        l[31:0] = 32'hDEAD_BEEF; l[63:32] = 32'hAAAA_AAAA;
        mem[32'h0000_0100] = l;

        @(negedge clk);
        chk(rd_data == 32'd0 && mem_addr == 32'd0, "reset_data_addr", {rd_data, mem_addr}, 0);
        chk({mem_rd_req, mem_wr_req, miss} == 3'b000, "reset_ctrl", {mem_rd_req, mem_wr_req, miss}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset during SWAP_IN, followed by a late grant that must be ignored.
        mem_hold = 1'b1;
        addr = 32'h0000_0100; rd_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_rd_req && n < 10);
        chk(mem_rd_req && !mem_wr_req, "abort_swapin", {mem_rd_req, mem_wr_req}, 2'b10);
        chk(mem_addr == 32'h0000_0100, "abort_addr", mem_addr, 32'h0000_0100);
        @(posedge clk); #1 rst = 1'b1; rd_req = 1'b0;
        #1;
        chk({mem_rd_req, mem_wr_req, miss} == 3'b000 && mem_addr == 32'd0, "rst_async",
            {mem_rd_req, mem_wr_req, miss, mem_addr}, 0);
        @(posedge clk); #1 rst = 1'b0; late_gnt = 1'b1;
        repeat (3) @(negedge clk);
        chk(late_done && {mem_rd_req, mem_wr_req, miss} == 3'b000, "late_gnt", {late_done, mem_rd_req, mem_wr_req, miss}, 4'b1000);
        mem_hold = 1'b0;
        @(posedge clk); #1;

        // Directed walk through hit, store merge, dirty and clean conflicts, and rd+wr together.
        do_req(32'h0000_0100, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_0104, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_0104, 1'b0, 1'b1, 4'b0011, 32'h0000_1234);
        do_req(32'h0000_0104, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_4104, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_0100, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_0104, 1'b1, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_0100, 1'b1, 1'b1, 4'hF, 32'h5566_7788);
        do_req(32'h0000_0000, 1'b0, 1'b0, 4'h0, 32'h0);
        do_req(32'h0000_0100, 1'b1, 1'b0, 4'h0, 32'h0);

        // Random traffic over a few sets and tags to force frequent conflicts.
        for (int i = 0; i < 300; i++) begin
            a = {21'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            k = int'($urandom_range(0, 9));
            if (k < 4)      do_req(a, 1'b1, 1'b0, 4'h0, $urandom);
            else if (k < 8) do_req(a, 1'b0, 1'b1, 4'($urandom), $urandom);
            else if (k < 9) do_req(a, 1'b1, 1'b1, 4'($urandom), $urandom);
            else            do_req(a, 1'b0, 1'b0, 4'h0, 32'h0);
        end

        repeat (3) @(negedge clk);
        chk(exp_rd.size() == 0, "rd_queue_drained", exp_rd.size(), 0);
        chk(exp_mem.size() == 0, "mem_queue_drained", exp_mem.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Replaces the plain data RAM currently instanced in the WB-stage segment register; consumes the MEM-stage address, store data and byte-enables.
- Produces load data one cycle later, aligned with WB.
- Drives the hazard unit's DCacheMiss input, currently tied low, so the pipeline stalls while a line is swapped with main memory over a line-wide request/grant interface.

Parameters:
LINE_ADDR_LEN, 3, log2 words per line (8 words = 256-bit line)
SET_ADDR_LEN, 6, log2 number of lines (64 lines)
TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN, tag width (default 21)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-high
addr  in  32  byte address from MEM stage (AluOutM)
rd_req  in  1  load request (MemToRegM)
wr_req  in  1  store request (|MemWriteM)
wr_be  in  4  store byte enables (MemWriteM)
wr_data  in  32  store data, already lane-aligned (StoreDataM)
rd_data  out  32  loaded word, valid the cycle after a hit; goes to DataExt
miss  out  1  stall request to hazard unit (DCacheMiss)
mem_addr  out  32  line-aligned memory address
mem_rd_req  out  1  line fetch request
mem_wr_req  out  1  line write-back request
mem_wr_line  out  32<<LINE_ADDR_LEN  victim line data
mem_rd_line  in  32<<LINE_ADDR_LEN  fetched line data, valid with mem_gnt
mem_gnt  in  1  one-cycle completion pulse for the current request

Behaviour:
- Address split: [1:0] byte offset (unused, wr_be selects bytes); [LINE_ADDR_LEN+1:2] word; next SET_ADDR_LEN bits set; top TAG_ADDR_LEN bits tag.
- Per set storage: valid bit, dirty bit, tag, line data.
- hit = valid[set] && tag[set]==addr tag.
- Reset (async, any state):
  - all valid and dirty bits clear; state IDLE; rd_data=0.
  - mem_rd_req=0, mem_wr_req=0, mem_addr=0.
  - Tag and data contents are don't-care.
  - An in-flight memory transaction is abandoned, and a later mem_gnt is ignored.
- FSM states: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
  - IDLE, req && hit, read: rd_data <= data[set][word] at the edge.
  - IDLE, req && hit, write: byte-merge wr_data per wr_be into data[set][word] at the edge; dirty[set] <= 1.
  - IDLE, req && !hit: if valid&&dirty go to SWAP_OUT, else go to SWAP_IN.
  - SWAP_OUT: mem_wr_req=1; mem_addr={victim tag,set,0}; mem_wr_line=victim data. On mem_gnt go to SWAP_IN.
  - SWAP_IN: mem_rd_req=1; mem_addr={req tag,set,0}. On mem_gnt latch mem_rd_line and go to SWAP_IN_OK.
  - SWAP_IN_OK: install line, tag, valid=1, dirty=0; go to IDLE.
  - Back in IDLE the held request hits and completes as a normal hit.
- mem_rd_req, mem_wr_req and mem_addr are Moore outputs, registered from the state. They stay stable until mem_gnt. They are never both high.
- miss = (state!=IDLE) || ((rd_req||wr_req) && !hit). This is combinational so the requesting instruction stalls in the same cycle.
- The core holds addr, wr_data and requests stable while miss=1. If the request drops mid-swap, the swap still completes and the line is installed.
- rd_req && wr_req together: treated as a write; rd_data holds.
- No request: no state change; rd_data holds its last value.
- Write-miss allocate: fetched line installed clean, then the write hit in IDLE sets dirty.
- mem_gnt outside SWAP_OUT/SWAP_IN is ignored.
- Minimum miss penalty: clean miss 2 cycles plus memory latency; dirty miss adds one write-back.

Test Plan:
- After reset, rd_req addr=0x0000_0100 -> miss=1 the same cycle, then SWAP_IN with mem_addr=0x0000_0100. Grant with a line whose word0=0xDEAD_BEEF -> miss drops after SWAP_IN_OK, and rd_data=0xDEAD_BEEF the cycle after the hit.
- Hit read then wr_req addr=0x104, wr_be=4'b0011, wr_data=0x0000_1234 over an old word 0xAAAA_AAAA -> miss=0, and the following read of 0x104 returns 0xAAAA_1234.
- Dirty conflict: after the prior store, read 0x0000_4104 (same set, different tag) -> SWAP_OUT with mem_addr=0x100, mem_wr_line word1=0xAAAA_1234. Then SWAP_IN with mem_addr=0x4100, and miss stays high throughout.
- Clean conflict: miss on a clean line -> goes directly to SWAP_IN, and mem_wr_req is never asserted.
- Assert rst during SWAP_IN before mem_gnt -> outputs return to zero immediately. A late mem_gnt is ignored, and the next read of 0x100 misses again.
- Simultaneous rd_req and wr_req on a hit -> the store is applied and rd_data is unchanged.
